// File: rtl/spi_test_controller_pkg.sv
// Shared types and constants for the mode-0 SPI test controller.
package spi_ctrl_pkg;
  localparam int FRAME_BITS = 8;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int SPI_MODE   = 0;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;
endpackage

// File: rtl/spi_test_controller_if.sv
// Byte-level valid/ready front end plus SPI pins of the test controller.
interface spi_test_controller_if;
  import spi_ctrl_pkg::*;

  logic [FRAME_BITS-1:0] tx_data;
  logic                  tx_last;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  cs_n;

  modport master (
    input  tx_data, tx_last, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );

  modport slave (
    output tx_data, tx_last, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_test_controller_half_tick.sv
// Half-period counter: tick fires on the last enabled cycle of each sclk half-period.
module spi_half_tick #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  logic [7:0] cnt;

  assign tick = enable && (cnt == 8'(HALF_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 8'd1;
  end
endmodule

// File: rtl/spi_test_controller.sv
// Mode-0, MSB-first, 8-bit SPI initiator with burst chip-select control.
module spi_test_controller
  import spi_ctrl_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_test_controller_if.master bus
);
  if (HALF_PERIOD < 1 || HALF_PERIOD > 255) begin : g_bad_half_period
    $error("HALF_PERIOD must be within 1..255");
  end
  if (SPI_MODE != 0) begin : g_bad_mode
    $error("only SPI mode 0 is supported");
  end

  state_t                state, state_next;
  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  last_flag;
  logic                  sclk_q, mosi_q, cs_n_q, rx_valid_q;
  logic [FRAME_BITS-1:0] rx_data_q;
  logic                  tick, tick_clear, tick_en;
  logic                  accept, rise, fall, release_cs;

  assign bus.tx_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  assign accept     = bus.tx_valid && (state == IDLE);
  assign rise       = tick && (state == SETUP || state == LOW);
  assign fall       = tick && (state == HIGH);
  assign release_cs = tick && (state == DONE) && last_flag;

  // The rx_valid cycle is not part of the cs hold time, so it does not count.
  assign tick_clear = (state_next != state);
  assign tick_en    = (state != IDLE) && !(state == DONE && rx_valid_q);

  spi_half_tick #(.HALF_PERIOD(HALF_PERIOD)) u_half_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tick_clear),
    .enable (tick_en),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (tick) state_next = HIGH;
      HIGH:    if (tick) state_next = (bit_cnt == '0) ? DONE : LOW;
      LOW:     if (tick) state_next = HIGH;
      DONE:    if (!last_flag || tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      if (accept) begin
        cs_n_q <= 1'b0;
        mosi_q <= bus.tx_data[FRAME_BITS-1];
      end
      if (rise) sclk_q <= 1'b1;
      if (fall) begin
        sclk_q <= 1'b0;
        if (bit_cnt == '0) begin
          rx_data_q  <= shreg;
          rx_valid_q <= 1'b1;
        end else begin
          mosi_q <= shreg[FRAME_BITS-1];
        end
      end
      if (release_cs) cs_n_q <= 1'b1;
    end
  end

  // Shifting on the rise keeps the next tx bit in shreg[7] for the following
  // fall, and leaves the full received byte in shreg after the 8th rise.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg     <= bus.tx_data;
      bit_cnt   <= CNT_W'(FRAME_BITS - 1);
      last_flag <= bus.tx_last;
    end
    if (rise) shreg <= {shreg[FRAME_BITS-2:0], bus.miso};
    if (fall && bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
  end
endmodule

// File: tb/tb_spi_test_controller.sv
// Directed bench for spi_test_controller with a loopback / fixed-reply SPI peripheral.
module tb_spi_test_controller;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_test_controller_if bus ();

  spi_test_controller #(.HALF_PERIOD(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Peripheral: either echoes mosi, or shifts out resp, updating on sclk fall.
  bit         loopback;
  logic [7:0] resp;
  logic [7:0] per_sh;
  assign bus.miso = loopback ? bus.mosi : per_sh[7];
  always @(negedge bus.cs_n) per_sh = resp;
  always @(negedge bus.sclk) if (!bus.cs_n) per_sh = {per_sh[6:0], 1'b0};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         acc_cnt, acc_cyc, rxv_cnt, rxv_cyc, rise_cnt, first_rise_cyc;
  int         csf_cnt, csf_cyc, csr_cnt, csr_cyc;
  logic [15:0] mosi_sh;
  logic [7:0]  rx_log [4];
  logic        sclk_prev = 1'b0;
  logic        cs_prev   = 1'b1;

  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (bus.rx_valid) begin
      if (rxv_cnt < 4) rx_log[rxv_cnt[1:0]] = bus.rx_data;
      rxv_cnt++;
      rxv_cyc = cyc;
    end
    if (bus.sclk && !sclk_prev && !bus.cs_n) begin
      if (rise_cnt == 0) first_rise_cyc = cyc;
      rise_cnt++;
      mosi_sh = {mosi_sh[14:0], bus.mosi};
    end
    if (!bus.cs_n && cs_prev) begin
      csf_cnt++;
      csf_cyc = cyc;
    end
    if (bus.cs_n && !cs_prev) begin
      csr_cnt++;
      csr_cyc = cyc;
    end
    sclk_prev = bus.sclk;
    cs_prev   = bus.cs_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    acc_cnt = 0; rxv_cnt = 0; rise_cnt = 0; csf_cnt = 0; csr_cnt = 0;
    acc_cyc = 0; rxv_cyc = 0; first_rise_cyc = 0; csf_cyc = 0; csr_cyc = 0;
    mosi_sh = '0;
    for (int i = 0; i < 4; i++) rx_log[i] = '0;
  endtask

  // Presents a byte, returns just after the accepting edge with the source scrambled.
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    bus.tx_data  = d;
    bus.tx_last  = l;
    bus.tx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_ready && n < 300);
    check("accept_timeout", 32'(n < 300), 32'd1);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~d;
    bus.tx_last  = ~l;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || !bus.cs_n) && n < 400);
    check("idle_timeout", 32'(n < 400), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.tx_data  = '0;
    bus.tx_last  = 1'b0;
    bus.tx_valid = 1'b0;
    loopback     = 1'b1;
    resp         = '0;
    per_sh       = '0;
    clear_mon();

    // Reset: {cs_n, sclk, tx_ready, busy, rx_valid}
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({bus.cs_n, bus.sclk, bus.tx_ready, bus.busy, bus.rx_valid}), 32'b10100);
    end
    check("reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("reset_mosi", 32'(bus.mosi), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Loopback 0xA5, last=1
    clear_mon();
    send(8'hA5, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("lb_mosi_bits", 32'(mosi_sh[7:0]), 32'hA5);
    check("lb_rx_data", 32'(rx_log[0]), 32'hA5);
    check("lb_rx_held", 32'(bus.rx_data), 32'hA5);
    check("lb_rx_count", 32'(rxv_cnt), 32'd1);
    check("lb_sclk_rises", 32'(rise_cnt), 32'd8);
    check("lb_csn_fall_lat", 32'(csf_cyc - acc_cyc), 32'd1);
    check("lb_first_rise_lat", 32'(first_rise_cyc - csf_cyc), 32'(H));
    check("lb_rx_valid_lat", 32'(rxv_cyc - acc_cyc), 32'd33);
    check("lb_csn_rise_lat", 32'(csr_cyc - rxv_cyc), 32'd3);
    check("lb_mosi_hold", 32'(bus.mosi), 32'd1);

    // Peripheral returns 0x3C while 0x00 is sent
    @(posedge clk);
    #1;
    clear_mon();
    loopback = 1'b0;
    resp     = 8'h3C;
    send(8'h00, 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);
    check("reply_rx_data", 32'(rx_log[0]), 32'h3C);
    check("reply_sclk_rises", 32'(rise_cnt), 32'd8);
    check("reply_mosi_bits", 32'(mosi_sh[7:0]), 32'h00);
    check("reply_rx_count", 32'(rxv_cnt), 32'd1);

    // Burst 0x12 (open) then 0x34 (close)
    @(posedge clk);
    #1;
    clear_mon();
    loopback = 1'b1;
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);
    check("burst_csn_falls", 32'(csf_cnt), 32'd1);
    check("burst_csn_rises", 32'(csr_cnt), 32'd1);
    check("burst_sclk_rises", 32'(rise_cnt), 32'd16);
    check("burst_rx_count", 32'(rxv_cnt), 32'd2);
    check("burst_rx0", 32'(rx_log[0]), 32'h12);
    check("burst_rx1", 32'(rx_log[1]), 32'h34);
    check("burst_mosi_bits", 32'(mosi_sh), 32'h1234);

    // tx_valid held high across a frame
    @(posedge clk);
    #1;
    clear_mon();
    begin
      int n = 0;
      bus.tx_data  = 8'h5A;
      bus.tx_last  = 1'b1;
      bus.tx_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!bus.tx_ready && n < 300);
      @(posedge clk);
      #1;
      bus.tx_data = 8'hC3;
      repeat (10) @(negedge clk);
      check("hold_tx_ready_low", 32'(bus.tx_ready), 32'd0);
      check("hold_busy", 32'(bus.busy), 32'd1);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.tx_ready && n < 300);
      check("hold_second_timeout", 32'(n < 300), 32'd1);
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
    end
    wait_idle();
    repeat (20) @(negedge clk);
    check("hold_accepts", 32'(acc_cnt), 32'd2);
    check("hold_rx_count", 32'(rxv_cnt), 32'd2);
    check("hold_rx0", 32'(rx_log[0]), 32'h5A);
    check("hold_rx1", 32'(rx_log[1]), 32'hC3);
    check("hold_sclk_rises", 32'(rise_cnt), 32'd16);
    check("hold_csn_falls", 32'(csf_cnt), 32'd2);

    // Reset on the 4th sclk rise, then a clean 0xFF loopback frame
    @(posedge clk);
    #1;
    clear_mon();
    send(8'hA5, 1'b1);
    begin
      int n = 0;
      while (rise_cnt < 4 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("abort_reach_timeout", 32'(n < 200), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("abort_csn", 32'(bus.cs_n), 32'd1);
    check("abort_sclk", 32'(bus.sclk), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_rx_valid", 32'(rxv_cnt), 32'd0);
    check("abort_rx_data", 32'(bus.rx_data), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    send(8'hFF, 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);
    check("post_abort_rx", 32'(rx_log[0]), 32'hFF);
    check("post_abort_rx_count", 32'(rxv_cnt), 32'd1);
    check("post_abort_rises", 32'(rise_cnt), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
